// File: rtl/ddr3_dfi_sram.sv
// ---------------------------------------------------------------------------
// ddr3_dfi_sram
//   DFI-side memory responder standing in for PHY + DDR3 device. Decodes
//   ACT/RD/WR/PRE, tracks the open row of each bank, stores BL8 bursts
//   (4 DFI beats) in an on-chip RAM and returns read bursts RD_LATENCY
//   cycles after the RD command.
//
// Ports:
//   clock, reset            controller clock, synchronous active-high reset
//   dfi_cke_i, dfi_cs_ni    clock enable / chip select (either inactive = NOP)
//   dfi_ras_ni/cas_ni/we_ni command encoding
//   dfi_bank_i, dfi_addr_i  bank, row/column address (bit 10 = A10)
//   dfi_wren_i, dfi_mask_i, dfi_data_i   write beat, byte mask (1 = skip), data
//   dfi_rden_i              read enable, only checked
//   dfi_valid_o, dfi_data_o read beat valid / data (data holds when not valid)
//   err_o                   sticky protocol error flags
//
// Configuration:
//   DFI_SRAM_CHECK_EN       compile in the protocol checker; otherwise err_o=0
// ---------------------------------------------------------------------------
module ddr3_dfi_sram #(
    parameter int DDR_ROW_BITS   = 13,
    parameter int DDR_COL_BITS   = 10,
    parameter int DFI_DATA_WIDTH = 32,
    parameter int MEM_ABITS      = 10,
    parameter int RD_LATENCY     = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        dfi_cke_i,
    input  logic                        dfi_cs_ni,
    input  logic                        dfi_ras_ni,
    input  logic                        dfi_cas_ni,
    input  logic                        dfi_we_ni,
    input  logic [2:0]                  dfi_bank_i,
    input  logic [DDR_ROW_BITS-1:0]     dfi_addr_i,
    input  logic                        dfi_wren_i,
    input  logic [DFI_DATA_WIDTH/8-1:0] dfi_mask_i,
    input  logic [DFI_DATA_WIDTH-1:0]   dfi_data_i,
    input  logic                        dfi_rden_i,
    output logic                        dfi_valid_o,
    output logic [DFI_DATA_WIDTH-1:0]   dfi_data_o,
    output logic [3:0]                  err_o
);

    localparam int MASK_W = DFI_DATA_WIDTH / 8;
    localparam int FULL_W = 3 + DDR_ROW_BITS + (DDR_COL_BITS - 3) + 2;
    localparam int BASE_W = MEM_ABITS - 2;

    typedef enum logic [2:0] {
        CMD_MRS = 3'b000, CMD_REF = 3'b001, CMD_PRE = 3'b010, CMD_ACT = 3'b011,
        CMD_WR  = 3'b100, CMD_RD  = 3'b101, CMD_ZQC = 3'b110, CMD_NOP = 3'b111
    } cmd_e;
    typedef enum logic { W_IDLE, W_BURST } wstate_e;
    typedef enum logic { R_IDLE, R_ISSUE } rstate_e;

    // Command decode: a deselected or clock-disabled bus is a NOP.
    cmd_e w_cmd;
    assign w_cmd = (dfi_cke_i && !dfi_cs_ni) ? cmd_e'({dfi_ras_ni, dfi_cas_ni, dfi_we_ni})
                                             : CMD_NOP;
    logic w_is_rd, w_is_wr;
    assign w_is_rd = (w_cmd == CMD_RD);
    assign w_is_wr = (w_cmd == CMD_WR);

    // ---------------- bank / open-row tracking ----------------
    logic [7:0]              r_open;
    logic [DDR_ROW_BITS-1:0] r_open_row [8];

    // NOTE: state registers use non-blocking assignments so every always_ff
    // sees the pre-edge value of every other register.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_open <= '0;
            for (int i = 0; i < 8; i++) r_open_row[i] <= '0;
        end else begin
            case (w_cmd)
                CMD_ACT: begin
                    r_open[dfi_bank_i]     <= 1'b1;
                    r_open_row[dfi_bank_i] <= dfi_addr_i;
                end
                CMD_PRE: begin
                    if (dfi_addr_i[10]) r_open             <= '0;
                    else                r_open[dfi_bank_i] <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Burst base: {bank, row, col[CSB:3], beat}, truncated. A closed bank
    // still uses its stale row.
    logic [FULL_W-1:0] w_full;
    logic [BASE_W-1:0] w_cmd_base;
    assign w_full     = {dfi_bank_i, r_open_row[dfi_bank_i], dfi_addr_i[DDR_COL_BITS-1:3], 2'b00};
    assign w_cmd_base = w_full[MEM_ABITS-1:2];

    // ---------------- write FSM ----------------
    wstate_e           r_wstate;
    logic [1:0]        r_wr_beat;
    logic [BASE_W-1:0] r_wr_base;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wstate  <= W_IDLE;
            r_wr_beat <= '0;
            r_wr_base <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: if (w_is_wr) begin
                    r_wr_base <= w_cmd_base;
                    // A beat arriving with the WR itself is beat 0.
                    r_wr_beat <= dfi_wren_i ? 2'd1 : 2'd0;
                    r_wstate  <= W_BURST;
                end
                W_BURST: if (dfi_wren_i) begin
                    r_wr_beat <= r_wr_beat + 2'd1;
                    if (r_wr_beat == 2'd3) r_wstate <= W_IDLE;
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    logic                 w_wr_en;
    logic [MEM_ABITS-1:0] w_wr_addr;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        w_wr_en   = 1'b0;
        w_wr_addr = {r_wr_base, r_wr_beat};
        if (r_wstate == W_BURST) begin
            w_wr_en = dfi_wren_i;
        end else if (w_is_wr) begin
            w_wr_en   = dfi_wren_i;
            w_wr_addr = {w_cmd_base, 2'b00};
        end
    end

    // ---------------- storage ----------------
    logic [DFI_DATA_WIDTH-1:0] r_mem [2**MEM_ABITS];

    // NOTE: the RAM has no reset; contents survive reset and map onto block RAM.
    always_ff @(posedge clock) begin
        if (w_wr_en) begin
            for (int b = 0; b < MASK_W; b++)
                if (!dfi_mask_i[b]) r_mem[w_wr_addr][b*8 +: 8] <= dfi_data_i[b*8 +: 8];
        end
    end

    // ---------------- read issue FSM ----------------
    rstate_e           r_rstate;
    logic [1:0]        r_rd_beat;
    logic [BASE_W-1:0] r_rd_base;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_rstate  <= R_IDLE;
            r_rd_beat <= '0;
            r_rd_base <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: if (w_is_rd) begin
                    r_rd_base <= w_cmd_base;
                    r_rd_beat <= 2'd1;          // beat 0 issues with the command
                    r_rstate  <= R_ISSUE;
                end
                R_ISSUE: begin
                    r_rd_beat <= r_rd_beat + 2'd1;
                    if (r_rd_beat == 2'd3) r_rstate <= R_IDLE;
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    logic                      w_iss_valid;
    logic [MEM_ABITS-1:0]      w_iss_addr;
    logic [DFI_DATA_WIDTH-1:0] w_iss_data;

    assign w_iss_valid = (r_rstate == R_ISSUE) || w_is_rd;
    assign w_iss_addr  = (r_rstate == R_ISSUE) ? {r_rd_base, r_rd_beat} : {w_cmd_base, 2'b00};

    // Write-first: bytes written this cycle to the issued word are forwarded.
    always_comb begin
        w_iss_data = r_mem[w_iss_addr];
        if (w_wr_en && (w_wr_addr == w_iss_addr)) begin
            for (int b = 0; b < MASK_W; b++)
                if (!dfi_mask_i[b]) w_iss_data[b*8 +: 8] = dfi_data_i[b*8 +: 8];
        end
    end

    // ---------------- latency line + output register ----------------
    logic [RD_LATENCY-1:0]     r_pipe_v;
    logic [DFI_DATA_WIDTH-1:0] r_pipe_d [RD_LATENCY];

    always_ff @(posedge clock) begin
        if (reset) r_pipe_v <= '0;
        else       r_pipe_v <= {r_pipe_v[RD_LATENCY-2:0], w_iss_valid};
    end

    // Data stages are qualified by r_pipe_v and need no reset.
    always_ff @(posedge clock) begin
        r_pipe_d[0] <= w_iss_data;
        for (int i = 1; i < RD_LATENCY; i++) r_pipe_d[i] <= r_pipe_d[i-1];
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            dfi_valid_o <= 1'b0;
            dfi_data_o  <= '0;
        end else begin
            dfi_valid_o <= r_pipe_v[RD_LATENCY-1];
            if (r_pipe_v[RD_LATENCY-1]) dfi_data_o <= r_pipe_d[RD_LATENCY-1];
        end
    end

    // ---------------- protocol checker ----------------
`ifdef DFI_SRAM_CHECK_EN
    logic [3:0] r_err;
    logic [3:0] w_err_set;
    assign w_err_set[0] = (w_is_rd || w_is_wr) && !r_open[dfi_bank_i];
    assign w_err_set[1] = (w_cmd == CMD_ACT) && r_open[dfi_bank_i];
    assign w_err_set[2] = (w_is_rd && r_rstate == R_ISSUE) || (w_is_wr && r_wstate == W_BURST);
    assign w_err_set[3] = (dfi_wren_i && r_wstate == W_IDLE && !w_is_wr)
                       || (w_cmd == CMD_REF && |r_open)
                       || (dfi_rden_i != w_iss_valid);

    always_ff @(posedge clock) begin
        if (reset) r_err <= '0;
        else       r_err <= r_err | w_err_set;
    end
    assign err_o = r_err;
`else
    assign err_o = '0;
`endif

    // Address bits outside the RAM window and the unchecked read enable.
    logic w_unused;
    assign w_unused = ^{w_full, dfi_addr_i[2:0], dfi_rden_i};

endmodule

// File: tb/tb_ddr3_dfi_sram.sv
// ---------------------------------------------------------------------------
// tb_ddr3_dfi_sram
//   Directed stimulus for ddr3_dfi_sram. Read tasks push hand-computed
//   expected beats (with their expected arrival cycle) into a scoreboard; an
//   independent monitor pops and compares whenever dfi_valid_o is high.
//   Error-flag expectations follow DFI_SRAM_CHECK_EN.
// ---------------------------------------------------------------------------
module tb_ddr3_dfi_sram;

    localparam int RDL = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        dfi_cke_i, dfi_cs_ni, dfi_ras_ni, dfi_cas_ni, dfi_we_ni;
    logic [2:0]  dfi_bank_i;
    logic [12:0] dfi_addr_i;
    logic        dfi_wren_i;
    logic [3:0]  dfi_mask_i;
    logic [31:0] dfi_data_i;
    logic        dfi_rden_i;
    logic        dfi_valid_o;
    logic [31:0] dfi_data_o;
    logic [3:0]  err_o;

    ddr3_dfi_sram #(.RD_LATENCY(RDL)) dut (
        .clock(clock), .reset(reset),
        .dfi_cke_i(dfi_cke_i), .dfi_cs_ni(dfi_cs_ni),
        .dfi_ras_ni(dfi_ras_ni), .dfi_cas_ni(dfi_cas_ni), .dfi_we_ni(dfi_we_ni),
        .dfi_bank_i(dfi_bank_i), .dfi_addr_i(dfi_addr_i),
        .dfi_wren_i(dfi_wren_i), .dfi_mask_i(dfi_mask_i), .dfi_data_i(dfi_data_i),
        .dfi_rden_i(dfi_rden_i),
        .dfi_valid_o(dfi_valid_o), .dfi_data_o(dfi_data_o), .err_o(err_o)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [3:0] exp_err(input logic [3:0] e);
`ifdef DFI_SRAM_CHECK_EN
        return e;
`else
        return 4'b0000 & e;
`endif
    endfunction

    // ---------------- scoreboard + monitor ----------------
    typedef struct {
        int          at;
        logic [31:0] data;
        bit          dc;
    } exp_t;
    exp_t sb[$];

    always @(negedge clock) begin
        if (dfi_valid_o) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", {31'b0, dfi_valid_o}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("beat_cycle", cyc, e.at);
                if (!e.dc) check("beat_data", dfi_data_o, e.data);
            end
        end else if (sb.size() > 0 && sb[0].at <= cyc) begin
            check("beat_valid", {31'b0, dfi_valid_o}, 32'd1);
            void'(sb.pop_front());
        end
    end

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_cmd(input logic [2:0] c, input logic [2:0] bank, input logic [12:0] addr);
        {dfi_ras_ni, dfi_cas_ni, dfi_we_ni} = c;
        dfi_bank_i = bank;
        dfi_addr_i = addr;
    endtask

    task automatic nop();
        set_cmd(3'b111, 3'd0, 13'd0);
    endtask

    task automatic cmd1(input logic [2:0] c, input logic [2:0] bank, input logic [12:0] addr);
        set_cmd(c, bank, addr);
        tick();
        nop();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        check("rst_valid", {31'b0, dfi_valid_o}, 32'd0);
        check("rst_data", dfi_data_o, 32'd0);
        check("rst_err", {28'b0, err_o}, 32'd0);
    endtask

    task automatic wr(input logic [2:0] bank, input logic [9:0] col,
                      input logic [3:0][31:0] d, input logic [3:0][3:0] m,
                      input bit same, input int gap);
        int first;
        first = same ? 1 : 0;
        set_cmd(3'b100, bank, {3'b000, col});
        if (same) begin
            dfi_wren_i = 1'b1;
            dfi_data_i = d[0];
            dfi_mask_i = m[0];
        end
        tick();
        nop();
        dfi_wren_i = 1'b0;
        for (int b = first; b < 4; b++) begin
            repeat (gap) tick();
            dfi_wren_i = 1'b1;
            dfi_data_i = d[b];
            dfi_mask_i = m[b];
            tick();
            dfi_wren_i = 1'b0;
        end
    endtask

    task automatic rd(input logic [2:0] bank, input logic [9:0] col,
                      input logic [3:0][31:0] e, input int nbeats, input bit dc);
        int n;
        set_cmd(3'b101, bank, {3'b000, col});
        dfi_rden_i = 1'b1;
        tick();
        n = cyc;
        for (int k = 0; k < nbeats; k++) sb.push_back('{at: n + RDL + k, data: e[k], dc: dc});
        nop();
        repeat (3) tick();
        dfi_rden_i = 1'b0;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 40 && sb.size() > 0; i++) tick();
        tick();
        check(name, sb.size(), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset      = 1'b1;
        dfi_cke_i  = 1'b1;
        dfi_cs_ni  = 1'b0;
        dfi_wren_i = 1'b0;
        dfi_rden_i = 1'b0;
        dfi_mask_i = 4'h0;
        dfi_data_i = 32'h0;
        nop();
        tick();
        do_reset();

        // Basic write / read on bank 0 row 5.
        cmd1(3'b011, 3'd0, 13'd5);
        wr(3'd0, 10'd0, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, '0, 1'b0, 0);
        rd(3'd0, 10'd0, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4, 1'b0);
        drain("drain_basic");
        check("hold_valid", {31'b0, dfi_valid_o}, 32'd0);
        check("hold_data", dfi_data_o, 32'h44444444);
        check("err_basic", {28'b0, err_o}, {28'b0, exp_err(4'b0000)});

        // Byte masking; second WR carries beat 0 with the command and has gaps.
        wr(3'd0, 10'd8, {32'h89ABCDEF, 32'h01234567, 32'hAABBCCDD, 32'h0A0B0C0D}, '0, 1'b0, 0);
        wr(3'd0, 10'd8, {32'h0, 32'h0, 32'h12345678, 32'h0},
           {4'hF, 4'hF, 4'b0011, 4'hF}, 1'b1, 2);
        rd(3'd0, 10'd8, {32'h89ABCDEF, 32'h01234567, 32'h1234CCDD, 32'h0A0B0C0D}, 4, 1'b0);
        drain("drain_mask");

        // Back-to-back reads 4 cycles apart: 8 contiguous beats.
        rd(3'd0, 10'd0, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111}, 4, 1'b0);
        rd(3'd0, 10'd8, {32'h89ABCDEF, 32'h01234567, 32'h1234CCDD, 32'h0A0B0C0D}, 4, 1'b0);
        drain("drain_b2b");
        check("err_b2b", {28'b0, err_o}, {28'b0, exp_err(4'b0000)});

        // Read from a never-activated bank.
        rd(3'd3, 10'd0, '0, 4, 1'b1);
        check("err_closed_rd", {28'b0, err_o}, {28'b0, exp_err(4'b0001)});
        drain("drain_closed");
        check("err_closed_sticky", {28'b0, err_o}, {28'b0, exp_err(4'b0001)});
        do_reset();

        // PRE all, then WR to the closed bank using its stale row 7.
        cmd1(3'b011, 3'd0, 13'd5);
        cmd1(3'b011, 3'd2, 13'd7);
        cmd1(3'b010, 3'd0, 13'h400);
        wr(3'd2, 10'd0, {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555}, '0, 1'b0, 0);
        check("err_pre_all", {28'b0, err_o}, {28'b0, exp_err(4'b0001)});
        cmd1(3'b011, 3'd2, 13'd7);
        rd(3'd2, 10'd0, {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555}, 4, 1'b0);
        drain("drain_stale");
        check("err_reopen", {28'b0, err_o}, {28'b0, exp_err(4'b0001)});
        do_reset();

        // REF with a bank open, then ACT to an open bank.
        cmd1(3'b011, 3'd1, 13'd3);
        cmd1(3'b001, 3'd0, 13'd0);
        check("err_ref", {28'b0, err_o}, {28'b0, exp_err(4'b1000)});
        cmd1(3'b011, 3'd1, 13'd4);
        check("err_act_open", {28'b0, err_o}, {28'b0, exp_err(4'b1010)});
        do_reset();

        // WR during a write burst is dropped; its beat still lands in the burst.
        cmd1(3'b011, 3'd0, 13'd5);
        cmd1(3'b100, 3'd0, 13'd16);
        dfi_wren_i = 1'b1; dfi_mask_i = 4'h0; dfi_data_i = 32'hC0DE0000;
        tick();
        set_cmd(3'b100, 3'd0, 13'd24);
        dfi_data_i = 32'hC0DE0001;
        tick();
        nop();
        dfi_data_i = 32'hC0DE0002;
        tick();
        dfi_data_i = 32'hC0DE0003;
        tick();
        dfi_wren_i = 1'b0;
        check("err_drop_wr", {28'b0, err_o}, {28'b0, exp_err(4'b0100)});
        rd(3'd0, 10'd16, {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000}, 4, 1'b0);
        drain("drain_drop");
        do_reset();

        // Reset during beat 2 of a read burst: only beats 0..2 appear.
        cmd1(3'b011, 3'd0, 13'd5);
        rd(3'd0, 10'd16, {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000}, 3, 1'b0);
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check("rst_mid_valid", {31'b0, dfi_valid_o}, 32'd0);
        tick();
        reset = 1'b0;
        repeat (10) tick();
        drain("drain_rst_mid");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule

// File: doc/ddr3_dfi_sram.md
# ddr3_dfi_sram

Synthesizable DFI-side memory responder that answers the command and data stream produced by `ddr3_ddl`. It acts as a stand-in for the PHY plus DDR3 device in loopback benches and FPGA bring-up builds. It decodes ACT/RD/WR/PRE, tracks open rows per bank, stores BL8 bursts (4 DFI beats of 32 bits) in a small on-chip RAM, and returns read bursts with a fixed latency on `dfi_valid_o`/`dfi_data_o`.

## Interface
- `DDR_ROW_BITS`, 13, row address width
- `DDR_COL_BITS`, 10, column address width
- `DFI_DATA_WIDTH`, 32, DFI data width; mask width = `DFI_DATA_WIDTH/8`
- `MEM_ABITS`, 10, RAM depth = 2^`MEM_ABITS` words
- `RD_LATENCY`, 4, cycles from RD sample to first read beat; legal range 2..15

Ports:
- `clock` in 1: controller clock
- `reset` in 1: synchronous, active-high
- `dfi_cke_i` in 1: clock enable; low forces NOP
- `dfi_cs_ni` in 1: chip select, active-low; high forces NOP
- `dfi_ras_ni`, `dfi_cas_ni`, `dfi_we_ni` in 1 each: command encoding
- `dfi_bank_i` in 3: bank address
- `dfi_addr_i` in `DDR_ROW_BITS`: row or column address; bit 10 is A10
- `dfi_wren_i` in 1: write beat valid
- `dfi_mask_i` in `DFI_DATA_WIDTH/8`: byte mask; 1 = byte not written
- `dfi_data_i` in `DFI_DATA_WIDTH`: write data
- `dfi_rden_i` in 1: read enable; checked only, not required for the response
- `dfi_valid_o` out 1: read beat valid
- `dfi_data_o` out `DFI_DATA_WIDTH`: read data
- `err_o` out 4: sticky protocol error flags

## Operation
- Command `{ras_n,cas_n,we_n}`:
  - 000 MRS: no effect
  - 001 REF: no effect
  - 010 PRE: close the bank; close all banks if A10=1
  - 011 ACT: latch the row into `open_row[bank]` and set `open[bank]`
  - 100 WR: start a write burst
  - 101 RD: start a read burst
  - 110 ZQC: no effect
  - 111 NOP: no effect
- Word address = `{bank, open_row[bank], col[CSB:3], beat[1:0]}`, truncated to the low `MEM_ABITS` bits. `col[2:0]` is ignored (bursts are BL8-aligned).
- **Write FSM** states: `W_IDLE`, `W_BURST`.
  - WR in `W_IDLE`: latch the base address, beat := 0, go to `W_BURST`.
  - Each cycle with `dfi_wren_i` in `W_BURST`: write the unmasked bytes at `base|beat`, then beat++.
  - After beat 3 is written, return to `W_IDLE`.
- **Read issue FSM** states: `R_IDLE`, `R_ISSUE`.
  - RD in `R_IDLE`: issue beat 0 in the same cycle, then beats 1..3 on the next three cycles. Return to `R_IDLE` after beat 3.
  - The RAM is read at issue. A write beat to the same word in the same cycle is forwarded (write-first).
  - Each issued beat enters a `RD_LATENCY`-deep valid/data delay line. Overlapping bursts queue naturally in the line.
- Back-to-back RD with a 4-cycle spacing is legal and produces 8 contiguous valid beats.
- RD or WR to a closed bank: the command is still executed, using the stale `open_row`.
- RD while in `R_ISSUE`, or WR while in `W_BURST`: the command is dropped and the current burst continues.
- Memory contents are not reset.

## Timing
- Reset values:
  - `dfi_valid_o`=0, `dfi_data_o`=0, `err_o`=0
  - all banks closed, both FSMs idle
  - delay line cleared
- An RD sampled at edge n gives `dfi_valid_o`=1 after edges n+`RD_LATENCY` through n+`RD_LATENCY`+3.
- `dfi_data_o` holds its last value while `dfi_valid_o`=0.
- Write beats are accepted at any gap after the WR, with no timeout. Gaps between beats are allowed.
- A WR and its first `dfi_wren_i` in the same cycle: that beat counts as beat 0.
- Reset mid-burst aborts both FSMs and the delay line on the next edge. A partially written burst keeps the beats already written.
- ACT and PRE to the same bank in one cycle is impossible (single command bus). A command and a write beat in the same cycle are both processed.

## Configuration
- `DFI_SRAM_CHECK_EN` defined: the protocol checker is compiled in. Flags are sticky until reset:
  - `err_o[0]`: RD/WR to a closed bank
  - `err_o[1]`: ACT to an open bank
  - `err_o[2]`: dropped overlapping RD/WR
  - `err_o[3]`: `dfi_wren_i` in `W_IDLE`, REF with any bank open, or `dfi_rden_i` mismatch against the issue FSM
- Not defined: `err_o` is tied to 0. Functional behaviour is otherwise identical.

## Test plan
- ACT b0 row 5; WR col 0 with data 11,22,33,44, mask 0; RD col 0 -> valid at n+4..n+7 with 11,22,33,44, and `err_o`=0.
- WR with beat 1 mask 4'b0011 over existing 0xAABBCCDD, data 0x12345678 -> read beat 1 = 0x1234CCDD.
- Two RDs 4 cycles apart to cols 0 and 8 -> 8 contiguous valid beats in order, with no bubble.
- RD to bank 3 without ACT, `DFI_SRAM_CHECK_EN` defined -> `err_o[0]`=1 and it stays set. Without the macro -> `err_o`=0.
- PRE with A10=1 after ACT on b0 and b2, then WR b2 -> `err_o[0]`=1. A REF issued while b1 is open -> `err_o[3]`=1.
- Reset asserted at beat 2 of a read burst -> `dfi_valid_o`=0 on the next edge and no further beats appear.
